// File: rtl/boilerplate_pkg.sv
// boilerplate_pkg
// Shared types and default parameter values for the boilerplate scheduler.
// Contents:
//   state_e           - scheduler FSM state encoding
//   DEF_NUM_REQ       - default number of requesters
//   DEF_PARAM1        - default datapath input width
//   DEF_PARAM2        - default datapath output width
//   DEF_DP_LATENCY    - default datapath latency in clock edges
package boilerplate_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_PARAM1     = 10;
    localparam int unsigned DEF_PARAM2     = 20;
    localparam int unsigned DEF_DP_LATENCY = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/boilerplate_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin grant selection. Picks the first asserted
// request at or after rr_ptr_i, scanning upward and wrapping to 0.
// Ports:
//   req_i     [NUM_REQ]  - request vector
//   rr_ptr_i  [IDX_W]    - index that has highest priority this cycle
//   grant_o   [NUM_REQ]  - one-hot grant, zero when no request
//   idx_o     [IDX_W]    - index of the granted requester (0 when none)
//   any_o                - at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [31:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(rr_ptr_i) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!any_o && req_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/boilerplate_scheduler.sv
// boilerplate_scheduler
// Shares one externally instantiated boilerplate datapath among NUM_REQ
// requesters. One transaction at a time: accept a request (round-robin),
// drive its operand onto dp_in, wait DP_LATENCY edges, capture dp_out and
// hold the response until the consumer takes it.
// Ports:
//   clk                     - clock, rising edge
//   reset                   - asynchronous active-low reset
//   req_valid [NUM_REQ]     - per-requester request valid
//   req_data  [NUM_REQ*P1]  - requester i operand in [i*PARAM1 +: PARAM1]
//   req_ready [NUM_REQ]     - one-hot-or-zero accept
//   dp_in     [PARAM1]      - registered operand to datapath
//   dp_out    [PARAM2]      - datapath result
//   rsp_valid               - response valid
//   rsp_id    [clog2(N)]    - requester owning the response
//   rsp_data  [PARAM2]      - captured datapath result
//   rsp_ready               - response consumer ready
//   busy                    - FSM not idle
module boilerplate_scheduler
    import boilerplate_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned PARAM1     = DEF_PARAM1,
    parameter int unsigned PARAM2     = DEF_PARAM2,
    parameter int unsigned DP_LATENCY = DEF_DP_LATENCY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*PARAM1-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [PARAM1-1:0]           dp_in,
    input  logic [PARAM2-1:0]           dp_out,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [PARAM2-1:0]           rsp_data,
    input  logic                        rsp_ready,
    output logic                        busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(DP_LATENCY + 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PARAM1-1:0] dp_in_q, dp_in_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]     rsp_id_q, rsp_id_d;
    logic [PARAM2-1:0] rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr_arbiter (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        dp_in_d     = dp_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    dp_in_d   = req_data[arb_idx*PARAM1 +: PARAM1];
                    rsp_id_d  = arb_idx;
                    cnt_d     = CW'(DP_LATENCY);
                    state_d   = StWait;
                end
            end
            StWait: begin
                // Counter holds the edges still to go; capture on the last one.
                if (cnt_q == CW'(1)) begin
                    rsp_data_d  = dp_out;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Next scan starts just past the requester that was served.
                    rr_ptr_d    = (rsp_id_q == IW'(NUM_REQ - 1)) ? '0 : rsp_id_q + IW'(1);
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            dp_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            dp_in_q     <= dp_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign dp_in     = dp_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule
